// File: rtl/sc_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port
// identifiers and the default burst limit for locked DMA transfers.
package sc_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/sc_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// A held DMA lock keeps port 1 as winner until the burst limit is reached;
// in that window port 0 is blocked even while port 1 is masked by its own
// acknowledge, so the burst is not broken by the ack cycle.
// Build option SC_DMEM_ARB_RR_EN: when both ports are eligible and no lock
// is active, the port not granted last wins. Without it, port 0 has fixed
// priority.
module sc_arb_pick
   import sc_arb_pkg::*;
#(
   parameter int CW        = 4,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic          elig0_i,
   input  logic          elig1_i,
   input  logic          req1_i,
   input  logic          lock1_i,
   input  logic          owner_i,
   input  logic [CW-1:0] burst_cnt_i,
   output logic          grant_valid_o,
   output logic          grant_port_o
);

   logic lock_hold;

   assign lock_hold = lock1_i && (owner_i == PORT_DMA) && req1_i &&
                      (burst_cnt_i < CW'(BURST_MAX));

   // Winner selection: lock hold first, then contention policy, then the single eligible port
   always_comb begin
      grant_valid_o = 1'b0;
      grant_port_o  = PORT_CPU;
      if (lock_hold) begin
         grant_valid_o = elig1_i;
         grant_port_o  = PORT_DMA;
      end else if (elig0_i && elig1_i) begin
         grant_valid_o = 1'b1;
`ifdef SC_DMEM_ARB_RR_EN
         grant_port_o  = ~owner_i;
`else
         grant_port_o  = PORT_CPU;
`endif
      end else if (elig0_i) begin
         grant_valid_o = 1'b1;
         grant_port_o  = PORT_CPU;
      end else if (elig1_i) begin
         grant_valid_o = 1'b1;
         grant_port_o  = PORT_DMA;
      end
   end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory / MMIO block.
// Each transaction runs IDLE (grant, bus registered) -> ACCESS (memory
// samples) -> CAPTURE (read data valid) -> ack pulse in the following IDLE.
// Address bit 7 (I/O vs RAM) passes through undecoded.
// Build option SC_DMEM_ARB_RR_EN selects round-robin contention handling
// inside sc_arb_pick.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// them until ackN is seen high for one cycle; rdataN is valid with ackN and
// held afterwards. A port is ineligible while its own ack is high.
module sc_dmem_arbiter
   import sc_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic          clock,
   input  logic          clr,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   input  logic          lock1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_datain,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dataout,
   output logic          busy,
   output logic          owner,
   output logic [1:0]    dbg_state
);

   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

   arb_state_e    state_q, state_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          mem_we_q, mem_we_d;
   logic          wr_q, wr_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;

   logic          grant_valid;
   logic          grant_port;

   sc_arb_pick #(
      .CW        (CW),
      .BURST_MAX (BURST_MAX)
   ) u_pick (
      .elig0_i       (req0 && !ack0_q),
      .elig1_i       (req1 && !ack1_q),
      .req1_i        (req1),
      .lock1_i       (lock1),
      .owner_i       (owner_q),
      .burst_cnt_i   (cnt_q),
      .grant_valid_o (grant_valid),
      .grant_port_o  (grant_port)
   );

   // Next-state, bus capture at grant, burst counter and ack/read-data update
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mem_we_d = 1'b0;
      wr_d     = wr_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d  = grant_port;
               addr_d   = (grant_port == PORT_DMA) ? addr1 : addr0;
               wdata_d  = (grant_port == PORT_DMA) ? wdata1 : wdata0;
               mem_we_d = (grant_port == PORT_DMA) ? we1 : we0;
               wr_d     = (grant_port == PORT_DMA) ? we1 : we0;
               state_d  = ACCESS;
            end
            if (grant_valid && (grant_port == PORT_CPU)) begin
               cnt_d = '0;
            end else if (!lock1) begin
               cnt_d = '0;
            end else if (grant_valid && (cnt_q < BMAX)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCESS: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (owner_q == PORT_DMA) begin
               ack1_d = 1'b1;
               if (!wr_q) rdata1_d = mem_dataout;
            end else begin
               ack0_d = 1'b1;
               if (!wr_q) rdata0_d = mem_dataout;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (clr) begin
         state_q  <= IDLE;
         owner_q  <= PORT_CPU;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_we_q <= 1'b0;
         wr_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mem_we_q <= mem_we_d;
         wr_q     <= wr_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata0     = rdata0_q;
   assign rdata1     = rdata1_q;
   assign mem_addr   = addr_q;
   assign mem_datain = wdata_q;
   assign mem_we     = mem_we_q;
   assign owner      = owner_q;
   assign busy       = (state_q == ACCESS) || (state_q == CAPTURE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Bench for sc_dmem_arbiter: directed transactions with a word-addressed
// synchronous memory model behind the arbiter. Expected {port, rdata} pairs
// are queued at issue time and popped by a monitor on every ack.
module tb_sc_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          clr;
   logic          req0, we0, req1, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_datain;
   logic          mem_we;
   logic [DW-1:0] mem_dataout;
   logic          busy, owner;
   logic [1:0]    dbg_state;

   logic [DW-1:0] mem [0:255];
   logic [DW:0]   exp_q[$];

   int checks = 0;
   int errors = 0;
   int we_cycles = 0;
   logic [AW-1:0] we_addr;
   logic [DW-1:0] we_data;

   sc_dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(8)) dut (
      .clock       (clock),
      .clr         (clr),
      .req0        (req0),
      .we0         (we0),
      .addr0       (addr0),
      .wdata0      (wdata0),
      .ack0        (ack0),
      .rdata0      (rdata0),
      .req1        (req1),
      .we1         (we1),
      .addr1       (addr1),
      .wdata1      (wdata1),
      .lock1       (lock1),
      .ack1        (ack1),
      .rdata1      (rdata1),
      .mem_addr    (mem_addr),
      .mem_datain  (mem_datain),
      .mem_we      (mem_we),
      .mem_dataout (mem_dataout),
      .busy        (busy),
      .owner       (owner),
      .dbg_state   (dbg_state)
   );

   // Clock
   always #5 clock = ~clock;

   // Memory model: synchronous write and registered read, one word per 4 bytes
   always @(posedge clock) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_datain;
      mem_dataout <= mem[mem_addr[9:2]];
   end

   // Write-strobe observer for pulse-width and bus-content checks
   always @(negedge clock) begin
      if (mem_we) begin
         we_cycles <= we_cycles + 1;
         we_addr   <= mem_addr;
         we_data   <= mem_datain;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every ack pops one expected {port, rdata}
   always @(negedge clock) begin
      logic [DW:0] e;
      logic [DW:0] a;
      if (!clr && (ack0 || ack1)) begin
         checks++;
         if (ack0 && ack1) begin
            errors++;
            $display("FAIL dual_ack: both ack0 and ack1 high");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with nothing expected", ack0, ack1);
         end else begin
            e = exp_q.pop_front();
            a = ack1 ? {1'b1, rdata1} : {1'b0, rdata0};
            if (a !== e) begin
               errors++;
               $display("FAIL ack_response: got port %0d data %0h expected port %0d data %0h",
                        a[DW], a[DW-1:0], e[DW], e[DW-1:0]);
            end
         end
      end
   end

   // Single transaction on one port; returns cycles from issue to ack
   task automatic do_xfer(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                          output int lat);
      exp_q.push_back({port, exp_rd});
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!(port ? ack1 : ack0) && lat < 20);
      if (!(port ? ack1 : ack0)) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout: port %0d no ack within %0d cycles", port, lat);
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int lat, cyc, t0, t1, nacks;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEADBEEF;
      clr = 1'b1;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
      repeat (2) @(negedge clock);

      // Reset state
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_datain", mem_datain, 0);
      check("rst_owner", owner, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      clr = 1'b0;
      @(negedge clock);

      // CPU read of word 4
      we_cycles = 0;
      do_xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
      check("cpu_read_latency", lat, 3);
      check("cpu_read_no_we", we_cycles, 0);
      repeat (3) @(negedge clock);
      check("rdata0_hold", rdata0, 32'hDEADBEEF);
      check("idle_busy", busy, 0);

      // DMA write to an I/O-range address
      we_cycles = 0;
      do_xfer(1'b1, 1'b1, 32'h84, 32'h5A, 32'h0, lat);
      check("dma_write_latency", lat, 3);
      check("dma_write_we_pulse", we_cycles, 1);
      check("dma_write_addr", we_addr, 32'h84);
      check("dma_write_data", we_data, 32'h5A);
      check("dma_write_mem", mem[33], 32'h5A);
      check("dma_owner", owner, 1);
      @(negedge clock);

      // DMA read-back, CPU write then read-back; CPU write leaves rdata0 alone
      do_xfer(1'b1, 1'b0, 32'h84, 32'h0, 32'h5A, lat);
      @(negedge clock);
      do_xfer(1'b0, 1'b1, 32'h20, 32'h1234, 32'hDEADBEEF, lat);
      @(negedge clock);
      do_xfer(1'b0, 1'b0, 32'h20, 32'h0, 32'h1234, lat);
      @(negedge clock);

      // Contention: both requests rise together
`ifdef SC_DMEM_ARB_RR_EN
      exp_q.push_back({1'b1, 32'h5A});
      exp_q.push_back({1'b0, 32'hDEADBEEF});
`else
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      exp_q.push_back({1'b1, 32'h5A});
`endif
      req0 = 1; we0 = 0; addr0 = 32'h10;
      req1 = 1; we1 = 0; addr1 = 32'h84;
      cyc = 0; t0 = -1; t1 = -1;
      while ((t0 < 0 || t1 < 0) && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (ack0) begin t0 = cyc; req0 = 0; end
         if (ack1) begin t1 = cyc; req1 = 0; end
      end
      check("contention_both_acked", (t0 >= 0) && (t1 >= 0), 1);
      check("contention_first_latency", (t0 < t1) ? t0 : t1, 3);
      check("contention_gap", (t0 < t1) ? (t1 - t0) : (t0 - t1), 3);
      repeat (2) @(negedge clock);

      // Locked DMA burst against continuous CPU traffic
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 32'h5A});
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      exp_q.push_back({1'b1, 32'h5A});
      req1 = 1; we1 = 0; addr1 = 32'h84; lock1 = 1;
      @(negedge clock);
      req0 = 1; we0 = 0; addr0 = 32'h10;
      nacks = 0; cyc = 0;
      while (nacks < 10 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (ack0 || ack1) nacks++;
      end
      req0 = 0; req1 = 0; lock1 = 0;
      check("lock_ack_count", nacks, 10);
      repeat (6) @(negedge clock);
      check("lock_queue_drained", exp_q.size(), 0);

      // Reset during ACCESS of a CPU write
      req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h77;
      @(negedge clock);
      check("rst_mid_state_access", dbg_state, 1);
      check("rst_mid_we_high", mem_we, 1);
      clr = 1; req0 = 0;
      @(negedge clock);
      check("rst_mid_mem_we", mem_we, 0);
      check("rst_mid_state", dbg_state, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rdata0", rdata0, 0);
      check("rst_mid_rdata1", rdata1, 0);
      check("rst_mid_mem_addr", mem_addr, 0);
      check("rst_mid_mem_datain", mem_datain, 0);
      check("rst_mid_owner", owner, 0);
      clr = 0;
      nacks = 0;
      repeat (6) begin
         @(negedge clock);
         if (ack0 || ack1) nacks++;
      end
      check("rst_mid_no_ack", nacks, 0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
